// File: rtl/img_pkg.sv
// Shared image-processing definitions: op modes, FSM states, luma weights,
// coordinate width and per-channel arithmetic helpers.
package img_pkg;

  localparam int COORD_W = 11;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_BRIGHT = 2'd1,
    MODE_INVERT = 2'd2,
    MODE_THRESH = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [15:0] LUMA_WR = 16'd77;
  localparam logic [15:0] LUMA_WG = 16'd150;
  localparam logic [15:0] LUMA_WB = 16'd29;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Add a signed 9-bit offset to an 8-bit channel in 10-bit signed
  // arithmetic and saturate the result to 0..255.
  function automatic logic [7:0] add_clamp(input logic [7:0] ch, input logic [8:0] off);
    logic signed [9:0] w_sum;
    w_sum = $signed({2'b00, ch}) + $signed({off[8], off});
    if (w_sum < 10'sd0) begin
      add_clamp = 8'd0;
    end else if (w_sum > 10'sd255) begin
      add_clamp = 8'd255;
    end else begin
      add_clamp = 8'(w_sum);
    end
  endfunction

  // Weighted luma; the weights sum to 256 so the 16-bit total never
  // overflows and the shifted result always fits 8 bits.
  function automatic logic [7:0] luma(input rgb_t px);
    logic [15:0] w_acc;
    w_acc = LUMA_WR * {8'd0, px.r} + LUMA_WG * {8'd0, px.g} + LUMA_WB * {8'd0, px.b};
    luma  = 8'(w_acc >> 8);
  endfunction

endpackage

// File: rtl/pixel_op.sv
// Combinational per-pixel operator: pass, brightness, invert, threshold.
module pixel_op
  import img_pkg::*;
(
  input  mode_e      i_mode,
  input  logic [8:0] i_offset,
  input  logic [7:0] i_thresh,
  input  rgb_t       i_px,
  output rgb_t       o_px
);

  logic [7:0] w_luma;
  logic [7:0] w_bin;

  // Luma and the resulting binary level are formed for every pixel.
  always_comb begin
    w_luma = luma(i_px);
    if (w_luma >= i_thresh) begin
      w_bin = 8'hFF;
    end else begin
      w_bin = 8'h00;
    end
  end

  // Select the operation requested for this frame.
  always_comb begin
    o_px = i_px;
    case (i_mode)
      MODE_PASS: begin
        o_px = i_px;
      end
      MODE_BRIGHT: begin
        o_px.r = add_clamp(i_px.r, i_offset);
        o_px.g = add_clamp(i_px.g, i_offset);
        o_px.b = add_clamp(i_px.b, i_offset);
      end
      MODE_INVERT: begin
        o_px.r = 8'd255 - i_px.r;
        o_px.g = 8'd255 - i_px.g;
        o_px.b = 8'd255 - i_px.b;
      end
      MODE_THRESH: begin
        o_px.r = w_bin;
        o_px.g = w_bin;
        o_px.b = w_bin;
      end
      default: begin
        o_px = i_px;
      end
    endcase
  end

endmodule

// File: rtl/pixel_process.sv
// Frame-level pixel processor: control FSM, raster counters and a two-stage
// pipeline (input capture, then operator result) feeding the image writer.
module pixel_process
  import img_pkg::*;
#(
  parameter int MAX_WIDTH  = 768,
  parameter int MAX_HEIGHT = 512
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                start,
  input  logic [31:0]         width,
  input  logic [31:0]         height,
  input  logic [1:0]          mode,
  input  logic [8:0]          offset,
  input  logic [7:0]          thresh,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_r,
  input  logic [7:0]          in_g,
  input  logic [7:0]          in_b,
  output logic [COORD_W-1:0]  row,
  output logic [COORD_W-1:0]  col,
  output logic [7:0]          DATA_WRITE_R,
  output logic [7:0]          DATA_WRITE_G,
  output logic [7:0]          DATA_WRITE_B,
  output logic                out_valid,
  output logic                busy,
  output logic                frame_done
);

  state_e               r_state;
  state_e               w_next_state;

  logic [COORD_W-1:0]   r_width;
  logic [COORD_W-1:0]   r_height;
  mode_e                r_mode;
  logic [8:0]           r_offset;
  logic [7:0]           r_thresh;

  logic [COORD_W-1:0]   r_in_row;
  logic [COORD_W-1:0]   r_in_col;

  logic                 r_s1_valid;
  rgb_t                 r_s1_px;
  logic [COORD_W-1:0]   r_s1_row;
  logic [COORD_W-1:0]   r_s1_col;

  logic                 r_out_valid;
  rgb_t                 r_out_px;
  logic [COORD_W-1:0]   r_out_row;
  logic [COORD_W-1:0]   r_out_col;
  logic                 r_frame_done;

  logic                 w_in_ready;
  logic                 w_busy;
  logic                 w_accept;
  logic                 w_start_ok;
  logic                 w_size_bad;
  logic                 w_col_last;
  logic                 w_last_beat;
  rgb_t                 w_op_px;

  assign w_start_ok  = (r_state == ST_IDLE) && start;
  assign w_size_bad  = (width == 32'd0) || (width > 32'(MAX_WIDTH)) ||
                       (height == 32'd0) || (height > 32'(MAX_HEIGHT));
  assign w_accept    = in_valid && w_in_ready;
  assign w_col_last  = (r_in_col == (r_width - 11'd1));
  assign w_last_beat = w_accept && w_col_last && (r_in_row == (r_height - 11'd1));

  // State register.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (w_size_bad) begin
            w_next_state = ST_DONE;
          end else begin
            w_next_state = ST_RUN;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_last_beat) begin
          w_next_state = ST_DRAIN;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // Nothing enters stage 1 here, and its last beat moves into the
        // output register on this edge, so one cycle empties the pipe.
        w_next_state = ST_DONE;
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State-decoded handshake and status outputs.
  always_comb begin
    w_in_ready = 1'b0;
    w_busy     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b0;
        w_busy     = 1'b0;
      end
      ST_RUN: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b1;
      end
      ST_DRAIN, ST_DONE: begin
        w_in_ready = 1'b0;
        w_busy     = 1'b1;
      end
      default: begin
        w_in_ready = 1'b0;
        w_busy     = 1'b0;
      end
    endcase
  end

  // Frame configuration captured when a start is honoured.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_width  <= 11'd0;
      r_height <= 11'd0;
      r_mode   <= MODE_PASS;
      r_offset <= 9'd0;
      r_thresh <= 8'd0;
    end else if (w_start_ok) begin
      r_width  <= width[COORD_W-1:0];
      r_height <= height[COORD_W-1:0];
      r_mode   <= mode_e'(mode);
      r_offset <= offset;
      r_thresh <= thresh;
    end
  end

  // Raster counters for the accepted input stream.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_in_row <= 11'd0;
      r_in_col <= 11'd0;
    end else if (w_start_ok) begin
      r_in_row <= 11'd0;
      r_in_col <= 11'd0;
    end else if (w_accept) begin
      if (w_col_last) begin
        r_in_col <= 11'd0;
        r_in_row <= r_in_row + 11'd1;
      end else begin
        r_in_col <= r_in_col + 11'd1;
      end
    end
  end

  // Stage 1: capture the accepted beat with its coordinate.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_s1_valid <= 1'b0;
      r_s1_px    <= '0;
      r_s1_row   <= 11'd0;
      r_s1_col   <= 11'd0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_px  <= {in_r, in_g, in_b};
        r_s1_row <= r_in_row;
        r_s1_col <= r_in_col;
      end
    end
  end

  pixel_op u_pixel_op (
    .i_mode   (r_mode),
    .i_offset (r_offset),
    .i_thresh (r_thresh),
    .i_px     (r_s1_px),
    .o_px     (w_op_px)
  );

  // Stage 2: register the processed pixel; data and coordinate hold when idle.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_out_valid <= 1'b0;
      r_out_px    <= '0;
      r_out_row   <= 11'd0;
      r_out_col   <= 11'd0;
    end else begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_px  <= w_op_px;
        r_out_row <= r_s1_row;
        r_out_col <= r_s1_col;
      end
    end
  end

  // Completion pulse follows the DONE cycle, after the final output beat.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= (r_state == ST_DONE);
    end
  end

  assign in_ready     = w_in_ready;
  assign busy         = w_busy;
  assign out_valid    = r_out_valid;
  assign row          = r_out_row;
  assign col          = r_out_col;
  assign DATA_WRITE_R = r_out_px.r;
  assign DATA_WRITE_G = r_out_px.g;
  assign DATA_WRITE_B = r_out_px.b;
  assign frame_done   = r_frame_done;

endmodule

// File: tb/tb_pixel_process.sv
// Directed self-checking bench for pixel_process.
module tb_pixel_process;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        start;
  logic [31:0] width;
  logic [31:0] height;
  logic [1:0]  mode;
  logic [8:0]  offset;
  logic [7:0]  thresh;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_r, in_g, in_b;
  logic [10:0] row, col;
  logic [7:0]  DATA_WRITE_R, DATA_WRITE_G, DATA_WRITE_B;
  logic        out_valid;
  logic        busy;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  pixel_process dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .width(width), .height(height),
    .mode(mode), .offset(offset), .thresh(thresh), .in_valid(in_valid),
    .in_ready(in_ready), .in_r(in_r), .in_g(in_g), .in_b(in_b), .row(row), .col(col),
    .DATA_WRITE_R(DATA_WRITE_R), .DATA_WRITE_G(DATA_WRITE_G), .DATA_WRITE_B(DATA_WRITE_B),
    .out_valid(out_valid), .busy(busy), .frame_done(frame_done)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  // Output monitor
  int          q_cyc[$];
  logic [10:0] q_row[$], q_col[$];
  logic [7:0]  q_r[$], q_g[$], q_b[$];
  int          fd_cnt = 0, fd_cyc = 0, fd_ov = 0, busy_err = 0;
  logic        prev_fd = 1'b0;

  always @(negedge HCLK) begin
    if (out_valid) begin
      q_cyc.push_back(cyc);
      q_row.push_back(row);
      q_col.push_back(col);
      q_r.push_back(DATA_WRITE_R);
      q_g.push_back(DATA_WRITE_G);
      q_b.push_back(DATA_WRITE_B);
    end
    if (frame_done) begin
      fd_cnt <= fd_cnt + 1;
      fd_cyc <= cyc;
    end
    if (frame_done && out_valid) fd_ov <= fd_ov + 1;
    if (prev_fd && busy) busy_err <= busy_err + 1;
    prev_fd <= frame_done;
  end

  logic [7:0] px_r[16], px_g[16], px_b[16];
  logic [7:0] ex_r[16], ex_g[16], ex_b[16];
  int start_cyc, first_acc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic clear_mon();
    q_cyc.delete(); q_row.delete(); q_col.delete();
    q_r.delete(); q_g.delete(); q_b.delete();
    fd_cnt = 0;
    fd_cyc = 0;
  endtask

  task automatic set_px(input int i, input logic [7:0] r, g, b, er, eg, eb);
    px_r[i] = r;  px_g[i] = g;  px_b[i] = b;
    ex_r[i] = er; ex_g[i] = eg; ex_b[i] = eb;
  endtask

  task automatic do_start(input logic [31:0] w, h, input logic [1:0] m,
                          input logic [8:0] off, input logic [7:0] th);
    start = 1'b1; width = w; height = h; mode = m; offset = off; thresh = th;
    start_cyc = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic feed(input int n, input bit gap, input bit poke);
    for (int i = 0; i < n; i++) begin
      int tries;
      tries = 0;
      in_valid = 1'b1; in_r = px_r[i]; in_g = px_g[i]; in_b = px_b[i];
      while (!in_ready && tries < 20) begin
        step();
        tries++;
      end
      if (i == 0) first_acc = cyc;
      step();
      in_valid = 1'b0;
      if (gap && i != n - 1) begin
        if (poke) begin
          start = 1'b1; width = 32'd1; height = 32'd1; mode = 2'd2;
        end
        step();
        start = 1'b0;
      end
    end
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && fd_cnt == 0; i++) step();
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic run_frame(input logic [31:0] w, h, input logic [1:0] m, input logic [8:0] off,
                           input logic [7:0] th, input int n, input bit gap, input bit poke);
    clear_mon();
    do_start(w, h, m, off, th);
    feed(n, gap, poke);
    wait_done(40);
  endtask

  task automatic check_beats(input string tag, input int n, input int w);
    check_eq({tag, "_nbeats"}, q_r.size(), n);
    check_eq({tag, "_fdcnt"}, fd_cnt, 1);
    for (int i = 0; i < n && i < q_r.size(); i++) begin
      check_eq($sformatf("%s_row%0d", tag, i), q_row[i], i / w);
      check_eq($sformatf("%s_col%0d", tag, i), q_col[i], i % w);
      check_eq($sformatf("%s_r%0d", tag, i), q_r[i], ex_r[i]);
      check_eq($sformatf("%s_g%0d", tag, i), q_g[i], ex_g[i]);
      check_eq($sformatf("%s_b%0d", tag, i), q_b[i], ex_b[i]);
    end
  endtask

  initial begin
    HRESETn = 1'b0; start = 1'b0; width = 32'd0; height = 32'd0; mode = 2'd0;
    offset = 9'd0; thresh = 8'd0; in_valid = 1'b0; in_r = 8'd0; in_g = 8'd0; in_b = 8'd0;
    step(); step(); step();
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_frame_done", frame_done, 0);
    check_eq("rst_rowcol", {row, col}, 0);
    check_eq("rst_data", {DATA_WRITE_R, DATA_WRITE_G, DATA_WRITE_B}, 0);
    HRESETn = 1'b1;
    step();

    // 2x2 pass-through, continuous input
    for (int i = 0; i < 4; i++)
      set_px(i, 8'(10 + i), 8'(20 + i), 8'(30 + i), 8'(10 + i), 8'(20 + i), 8'(30 + i));
    run_frame(32'd2, 32'd2, 2'd0, 9'd0, 8'd0, 4, 1'b0, 1'b0);
    check_beats("pass2x2", 4, 2);
    check_eq("pass2x2_first_lat", (q_cyc.size() > 0) ? q_cyc[0] - first_acc : -1, 2);
    check_eq("pass2x2_last_lat", (q_cyc.size() > 3) ? q_cyc[3] - first_acc : -1, 5);
    check_eq("pass2x2_fd_lat", fd_cyc - first_acc, 6);
    check_eq("hold_valid", out_valid, 0);
    check_eq("hold_r", DATA_WRITE_R, 13);
    check_eq("hold_rowcol", {row, col}, {11'd1, 11'd1});
    check_eq("idle_busy", busy, 0);

    // brightness +100 with saturation
    set_px(0, 8'd200, 8'd50, 8'd0, 8'd255, 8'd150, 8'd100);
    set_px(1, 8'd155, 8'd156, 8'd0, 8'd255, 8'd255, 8'd100);
    run_frame(32'd2, 32'd1, 2'd1, 9'd100, 8'd0, 2, 1'b0, 1'b0);
    check_beats("bright_p100", 2, 2);

    // brightness -50 clamping at zero (-50 as 9-bit two's complement)
    set_px(0, 8'd30, 8'd80, 8'd255, 8'd0, 8'd30, 8'd205);
    set_px(1, 8'd50, 8'd49, 8'd0, 8'd0, 8'd0, 8'd0);
    run_frame(32'd2, 32'd1, 2'd1, 9'h1CE, 8'd0, 2, 1'b0, 1'b0);
    check_beats("bright_m50", 2, 2);

    // threshold at 128: luma 255, 100, 128
    set_px(0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
    set_px(1, 8'd100, 8'd100, 8'd100, 8'd0, 8'd0, 8'd0);
    set_px(2, 8'd128, 8'd128, 8'd128, 8'd255, 8'd255, 8'd255);
    run_frame(32'd3, 32'd1, 2'd3, 9'd0, 8'd128, 3, 1'b0, 1'b0);
    check_beats("thresh", 3, 3);

    // 3x1 with in_valid 1,0,1,0,1 and a start pulse during RUN (mode 2 would invert)
    set_px(0, 8'd1, 8'd2, 8'd3, 8'd1, 8'd2, 8'd3);
    set_px(1, 8'd4, 8'd5, 8'd6, 8'd4, 8'd5, 8'd6);
    set_px(2, 8'd7, 8'd8, 8'd9, 8'd7, 8'd8, 8'd9);
    run_frame(32'd3, 32'd1, 2'd0, 9'd0, 8'd0, 3, 1'b1, 1'b1);
    check_beats("gappy", 3, 3);

    // illegal sizes: zero width and width above maximum
    run_frame(32'd0, 32'd2, 2'd0, 9'd0, 8'd0, 0, 1'b0, 1'b0);
    check_eq("w0_nbeats", q_r.size(), 0);
    check_eq("w0_fdcnt", fd_cnt, 1);
    check_eq("w0_fd_lat", fd_cyc - start_cyc, 2);
    run_frame(32'd769, 32'd2, 2'd0, 9'd0, 8'd0, 0, 1'b0, 1'b0);
    check_eq("w769_nbeats", q_r.size(), 0);
    check_eq("w769_fdcnt", fd_cnt, 1);
    check_eq("w769_fd_lat", fd_cyc - start_cyc, 2);

    // reset after 3 beats of a 4x4 frame
    for (int i = 0; i < 3; i++) set_px(i, 8'(40 + i), 8'd0, 8'd0, 8'(40 + i), 8'd0, 8'd0);
    clear_mon();
    do_start(32'd4, 32'd4, 2'd0, 9'd0, 8'd0);
    feed(3, 1'b0, 1'b0);
    HRESETn = 1'b0;
    step();
    HRESETn = 1'b1;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_in_ready", in_ready, 0);
    check_eq("midrst_rowcol", {row, col}, 0);
    check_eq("midrst_data", {DATA_WRITE_R, DATA_WRITE_G, DATA_WRITE_B}, 0);
    clear_mon();
    for (int i = 0; i < 10; i++) step();
    check_eq("midrst_nbeats", q_r.size(), 0);
    check_eq("midrst_fdcnt", fd_cnt, 0);

    // normal frame after reset, invert mode
    set_px(0, 8'd0, 8'd100, 8'd255, 8'd255, 8'd155, 8'd0);
    set_px(1, 8'd255, 8'd0, 8'd1, 8'd0, 8'd255, 8'd254);
    run_frame(32'd2, 32'd1, 2'd2, 9'd0, 8'd0, 2, 1'b0, 1'b0);
    check_beats("invert", 2, 2);

    check_eq("fd_with_out_valid", fd_ov, 0);
    check_eq("busy_after_fd", busy_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_process.md
PIXEL_PROCESS -- requirements
Module: pixel_process

Interface
REQ-001 Parameter MAX_WIDTH, 768, largest accepted frame width in pixels.
REQ-002 Parameter MAX_HEIGHT, 512, largest accepted frame height in pixels.
REQ-003 HCLK  in  1  single clock; all state updates on rising edge.
REQ-004 HRESETn  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  one-cycle request to begin a frame.
REQ-006 width, height  in  32 each  frame size, sampled at accepted start.
REQ-007 mode  in  2  op select: 0 pass, 1 brightness, 2 invert, 3 threshold; sampled at start.
REQ-008 offset  in  9  signed brightness offset, sampled at start.
REQ-009 thresh  in  8  luma threshold, sampled at start.
REQ-010 in_valid  in  1  input pixel beat present.
REQ-011 in_ready  out  1  block accepts beat this cycle.
REQ-012 in_r, in_g, in_b  in  8 each  input pixel, raster order from top-left.
REQ-013 row, col  out  11 each  coordinate of the presented output pixel.
REQ-014 DATA_WRITE_R/G/B  out  8 each  processed pixel to the downstream writer.
REQ-015 out_valid  out  1  output pixel new this cycle.
REQ-016 busy  out  1  high in any state but IDLE.
REQ-017 frame_done  out  1  one-cycle pulse after the last output pixel.

Function
REQ-018 FSM states IDLE, RUN, DRAIN, DONE; start is honoured only in IDLE and ignored in all other states.
REQ-019 IDLE + start: latch width/height/mode/offset/thresh, clear raster counters, go RUN; if width or height is 0 or exceeds MAX_WIDTH/MAX_HEIGHT, go DONE directly with no output beats.
REQ-020 in_ready is 1 only in RUN; a beat is accepted when in_valid and in_ready are both 1; gaps in in_valid stall the counters.
REQ-021 Input col counter increments per accepted beat; at width-1 it wraps to 0 and row increments; the beat at (height-1, width-1) moves the FSM to DRAIN in the same edge.
REQ-022 Two-stage pipeline: an accepted beat appears with out_valid=1 exactly 2 cycles later; row/col travel with the data.
REQ-023 DRAIN holds in_ready=0 until the pipeline is empty, then goes DONE; DONE asserts frame_done for one cycle and returns to IDLE.
REQ-024 mode 0: output equals input.
REQ-025 mode 1: each channel = clamp(channel + offset, 0, 255), computed in 10-bit signed arithmetic.
REQ-026 mode 2: each channel = 255 - channel.
REQ-027 mode 3: luma = (77R + 150G + 29B) >> 8 (16-bit sum, result fits 8 bits); all channels = 255 if luma >= thresh, else 0.
REQ-028 When out_valid=0, row, col and DATA_WRITE_* hold their last values, so a downstream writer rewriting the same location is harmless.
REQ-029 frame_done never coincides with out_valid; busy is low in the cycle after frame_done.

Reset
REQ-030 HRESETn=0 at any edge forces IDLE and clears counters and pipeline valids; the next cycle has in_ready=0, out_valid=0, busy=0, frame_done=0, row=col=0, DATA_WRITE_*=0.
REQ-031 Reset mid-frame discards in-flight pixels and emits no frame_done; latched configuration is cleared to 0.

Structure
REQ-032 Shared package img_pkg holds: mode encodings, FSM state enum, luma weights 77/150/29, and the 11-bit coordinate width, reused by the image writer.
REQ-033 Per-pixel arithmetic (REQ-024..027) lives in one combinational sub-module pixel_op; pixel_process owns the FSM, counters and pipeline registers.

Verification
REQ-034 2x2 frame, mode 0, continuous in_valid, pixels (10,20,30)..: out_valid on cycles 2-5 after the first accept, row/col sequence (0,0),(0,1),(1,0),(1,1); frame_done 1 cycle after the last beat.
REQ-035 mode 1, offset=+100: input R=200 gives 255; offset=-50: R=30 gives 0 and G=80 gives 30.
REQ-036 mode 3, thresh=128: (255,255,255) gives 255s; (100,100,100), luma=100, gives 0s; (128,128,128) gives 255s.
REQ-037 3x1 frame with in_valid toggling 1,0,1,0,1: exactly 3 out_valid beats, col 0,1,2; start pulsed during RUN is ignored.
REQ-038 width=0 start: frame_done 2 cycles after start, zero out_valid beats; width=769 behaves the same.
REQ-039 Reset asserted after 3 beats of a 4x4 frame: next cycle busy=0, out_valid=0, no frame_done ever; a new start then completes normally.
